// File: rtl/ifetch_stage_pkg.sv
// Shared types for the LC-3b instruction-fetch stage: bus word, fetch FSM
// encoding and the {word, pc} entry held by the skid register.
package ifetch_stage_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        SKID    = 2'd3
    } lc3b_fetch_state;

    typedef struct packed {
        lc3b_word word;
        lc3b_word pc;
    } fetch_entry_t;

    // Instructions are halfword aligned, so a redirect target never carries bit 0.
    function automatic lc3b_word align_pc(input lc3b_word pc);
        return {pc[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read handshake plus the
// valid/stall/redirect interface towards the IR/decode stage.
interface ifetch_stage_if;
    import ifetch_stage_pkg::*;

    lc3b_word imem_address;
    logic     imem_read;
    lc3b_word imem_rdata;
    logic     imem_resp;

    logic     stall;
    logic     redirect;
    lc3b_word redirect_pc;
    logic     if_valid;
    lc3b_word if_ir;
    lc3b_word if_pc;
    lc3b_word if_pc_plus2;

    modport master (
        output imem_address, imem_read,
        input  imem_rdata, imem_resp,
        input  stall, redirect, redirect_pc,
        output if_valid, if_ir, if_pc, if_pc_plus2
    );

    modport slave (
        input  imem_address, imem_read,
        output imem_rdata, imem_resp,
        output stall, redirect, redirect_pc,
        input  if_valid, if_ir, if_pc, if_pc_plus2
    );

endinterface

// File: rtl/ifetch_skid.sv
// One-entry {word, pc} holding register that catches a fetched instruction
// arriving while decode is stalled on the previous one.
module ifetch_skid
    import ifetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         clear,
    input  fetch_entry_t d,
    output fetch_entry_t q
);

    // Clear wins over load: a redirect must never leave wrong-path data behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs a held-request read to
// instruction memory and hands {if_ir, if_pc} to decode through valid/stall.
module ifetch_stage
    import ifetch_stage_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000,
    parameter int       WORD_W   = 16
)
(
    input  logic           clk,
    input  logic           reset_n,
    ifetch_stage_if.master bus
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_FETCH   = FETCH;
    localparam logic [1:0] ST_DISCARD = DISCARD;
    localparam logic [1:0] ST_SKID    = SKID;

    localparam lc3b_word INSTR_BYTES = lc3b_word'(WORD_W / 8);

    logic [1:0]   state;
    lc3b_word     fetch_pc;
    lc3b_word     req_addr;
    logic         if_valid;
    lc3b_word     if_ir;
    lc3b_word     if_pc;

    lc3b_word     new_pc;
    logic         resp_taken;
    logic         take_direct;
    logic         skid_load;
    logic         skid_clear;
    fetch_entry_t skid_d;
    fetch_entry_t skid_q;

    assign new_pc = align_pc(bus.redirect_pc);

    // A response is only usable in FETCH and only when no redirect competes for the edge.
    assign resp_taken  = (state == ST_FETCH) && !bus.redirect && bus.imem_resp;
    assign take_direct = resp_taken && (!if_valid || !bus.stall);
    assign skid_load   = resp_taken && if_valid && bus.stall;
    assign skid_clear  = (state == ST_SKID) && (bus.redirect || !bus.stall);
    assign skid_d      = '{word: bus.imem_rdata, pc: fetch_pc};

    ifetch_skid u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d       (skid_d),
        .q       (skid_q)
    );

    // DISCARD keeps presenting the address of the pending read even after fetch_pc moved on.
    assign bus.imem_read    = (state == ST_FETCH) || (state == ST_DISCARD);
    assign bus.imem_address = (state == ST_DISCARD) ? req_addr : fetch_pc;

    assign bus.if_valid    = if_valid;
    assign bus.if_ir       = if_ir;
    assign bus.if_pc       = if_pc;
    assign bus.if_pc_plus2 = if_pc + INSTR_BYTES;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            if_valid <= 1'b0;
            if_ir    <= '0;
            if_pc    <= '0;
        end else begin
            if (if_valid && !bus.stall) begin
                if_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                    if (bus.redirect) begin
                        fetch_pc <= new_pc;
                    end
                end

                ST_FETCH: begin
                    if (bus.redirect) begin
                        fetch_pc <= new_pc;
                        if (!bus.imem_resp) begin
                            req_addr <= fetch_pc;
                            state    <= ST_DISCARD;
                        end
                    end else if (bus.imem_resp) begin
                        fetch_pc <= fetch_pc + INSTR_BYTES;
                        if (take_direct) begin
                            if_ir    <= bus.imem_rdata;
                            if_pc    <= fetch_pc;
                            if_valid <= 1'b1;
                        end else begin
                            state <= ST_SKID;
                        end
                    end
                end

                ST_DISCARD: begin
                    if (bus.redirect) begin
                        fetch_pc <= new_pc;
                    end
                    if (bus.imem_resp) begin
                        state <= ST_FETCH;
                    end
                end

                ST_SKID: begin
                    if (bus.redirect) begin
                        fetch_pc <= new_pc;
                        state    <= ST_FETCH;
                    end else if (!bus.stall) begin
                        if_ir    <= skid_q.word;
                        if_pc    <= skid_q.pc;
                        if_valid <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end

                default: state <= ST_IDLE;
            endcase

            // Redirect squashes whatever decode is looking at, including a same-edge load.
            if (bus.redirect) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: directed stimulus pushes expected words
// and read addresses; a negedge monitor pops and compares them.
module tb_ifetch_stage;
    import ifetch_stage_pkg::*;

    typedef struct {
        lc3b_word ir;
        lc3b_word pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    ifetch_stage_if bus ();

    ifetch_stage #(.RESET_PC(16'h3000), .WORD_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int       n_cmp = 0;
    int       n_bad = 0;
    exp_t     exp_q[$];
    lc3b_word addr_q[$];
    int       mem_lat = 1;
    int       mem_cnt = 0;
    logic     mem_en = 1'b1;

    task automatic chk16(input string name, input lc3b_word act, input lc3b_word exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic lc3b_word mem_word(input lc3b_word a);
        case (a)
            16'h3000: return 16'h1111;
            16'h3002: return 16'h1234;
            default:  return ~a;
        endcase
    endfunction

    // Instruction memory: responds mem_lat cycles after it first sees a read.
    initial begin
        bus.imem_resp  = 1'b0;
        bus.imem_rdata = 16'hDEAD;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_resp  = 1'b0;
            bus.imem_rdata = 16'hDEAD;
            if (!reset_n || !bus.imem_read || !mem_en) begin
                mem_cnt = 0;
            end else if (mem_cnt >= mem_lat) begin
                bus.imem_resp  = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_address);
                mem_cnt = 0;
            end else begin
                mem_cnt++;
            end
        end
    end

    // Monitor: decode accepts at the next edge when if_valid && !stall.
    initial begin
        exp_t     e;
        lc3b_word a;
        forever begin
            @(negedge clk);
            if (reset_n && bus.if_valid && !bus.stall) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got ir=%h pc=%h, expected none", bus.if_ir, bus.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk16("word_ir", bus.if_ir, e.ir);
                    chk16("word_pc", bus.if_pc, e.pc);
                    chk16("word_pc_plus2", bus.if_pc_plus2, e.pc + 16'd2);
                end
            end
            if (reset_n && bus.imem_read && bus.imem_resp) begin
                if (addr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got addr=%h, expected none", bus.imem_address);
                end else begin
                    a = addr_q.pop_front();
                    chk16("resp_addr", bus.imem_address, a);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        reset_n         = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        repeat (3) @(posedge clk);
        #2;
        chk1 ("rst_valid", bus.if_valid, 1'b0);
        chk1 ("rst_read", bus.imem_read, 1'b0);
        chk16("rst_ir", bus.if_ir, 16'h0000);
        chk16("rst_pc", bus.if_pc, 16'h0000);
        chk16("rst_addr", bus.imem_address, 16'h3000);
        chk16("rst_plus2", bus.if_pc_plus2, 16'h0002);

        // Sequential fetch into a stalled decode: 3002 lands in the skid.
        addr_q.push_back(16'h3000);
        addr_q.push_back(16'h3002);
        addr_q.push_back(16'h3004);
        exp_q.push_back('{ir: 16'h1111, pc: 16'h3000});
        exp_q.push_back('{ir: 16'h1234, pc: 16'h3002});
        reset_n = 1'b1;
        chk1("idle_read", bus.imem_read, 1'b0);
        step();
        chk1 ("first_read", bus.imem_read, 1'b1);
        chk16("first_addr", bus.imem_address, 16'h3000);
        for (int i = 0; i < 20 && !(bus.if_valid && bus.if_pc == 16'h3000); i++) step();
        chk1("t1_word_3000", bus.if_valid && bus.if_pc == 16'h3000, 1'b1);
        bus.stall = 1'b1;
        for (int i = 0; i < 20 && bus.imem_read; i++) step();
        chk1 ("t2_skid_read", bus.imem_read, 1'b0);
        chk16("t2_hold_ir", bus.if_ir, 16'h1111);
        mem_lat = 3;
        step();
        step();
        chk1 ("t2_skid_still_idle", bus.imem_read, 1'b0);
        chk1 ("t2_skid_valid", bus.if_valid, 1'b1);
        bus.stall = 1'b0;
        step();
        chk16("t2_skid_ir", bus.if_ir, 16'h1234);
        chk16("t2_skid_pc", bus.if_pc, 16'h3002);
        chk1 ("t2_resume_read", bus.imem_read, 1'b1);
        chk16("t2_resume_addr", bus.imem_address, 16'h3004);

        // Redirect while 3004 is outstanding with a slow memory.
        addr_q.push_back(16'h4000);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h4001;
        step();
        bus.redirect = 1'b0;
        chk1("t3_valid_cleared", bus.if_valid, 1'b0);
        for (int i = 0; i < 10 && !bus.imem_resp; i++) begin
            chk16("t3_hold_addr", bus.imem_address, 16'h3004);
            chk1 ("t3_hold_read", bus.imem_read, 1'b1);
            step();
        end
        chk1 ("t3_resp_seen", bus.imem_resp, 1'b1);
        chk16("t3_resp_addr", bus.imem_address, 16'h3004);
        mem_lat = 1;
        step();
        chk1 ("t3_dropped", bus.if_valid, 1'b0);
        chk16("t3_next_addr", bus.imem_address, 16'h4000);

        // Redirect in the same cycle as the 4000 response.
        addr_q.push_back(16'h5000);
        addr_q.push_back(16'h5002);
        exp_q.push_back('{ir: 16'hAFFF, pc: 16'h5000});
        exp_q.push_back('{ir: 16'hAFFD, pc: 16'h5002});
        for (int i = 0; i < 10 && !bus.imem_resp; i++) step();
        chk1 ("t4_resp_4000", bus.imem_resp, 1'b1);
        chk16("t4_resp_addr", bus.imem_address, 16'h4000);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h5000;
        step();
        bus.redirect = 1'b0;
        chk1 ("t4_no_load", bus.if_valid, 1'b0);
        chk1 ("t4_read", bus.imem_read, 1'b1);
        chk16("t4_addr", bus.imem_address, 16'h5000);

        // Redirect to an odd top-of-memory target, then wrap.
        for (int i = 0; i < 20 && !(bus.if_valid && bus.if_pc == 16'h5002); i++) step();
        chk1("t5_word_5002", bus.if_valid && bus.if_pc == 16'h5002, 1'b1);
        addr_q.push_back(16'h5004);
        addr_q.push_back(16'hFFFE);
        addr_q.push_back(16'h0000);
        exp_q.push_back('{ir: 16'h0001, pc: 16'hFFFE});
        exp_q.push_back('{ir: 16'hFFFF, pc: 16'h0000});
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        step();
        bus.redirect = 1'b0;
        chk16("t5_discard_addr", bus.imem_address, 16'h5004);
        for (int i = 0; i < 20 && !(bus.if_valid && bus.if_pc == 16'hFFFE); i++) step();
        chk16("t5_pc_fffe", bus.if_pc, 16'hFFFE);
        chk16("t5_plus2_wrap", bus.if_pc_plus2, 16'h0000);
        chk16("t5_addr_wrap", bus.imem_address, 16'h0000);
        for (int i = 0; i < 20 && !(bus.if_valid && bus.if_pc == 16'h0000); i++) step();
        chk1("t5_word_0000", bus.if_valid && bus.if_pc == 16'h0000, 1'b1);

        // Reset with the 0002 read outstanding.
        step();
        reset_n = 1'b0;
        #1;
        chk1 ("t6_rst_valid", bus.if_valid, 1'b0);
        chk1 ("t6_rst_read", bus.imem_read, 1'b0);
        chk16("t6_rst_addr", bus.imem_address, 16'h3000);
        chk16("t6_rst_ir", bus.if_ir, 16'h0000);
        step();
        addr_q.push_back(16'h3000);
        addr_q.push_back(16'h3002);
        reset_n = 1'b1;
        chk1("t6_idle_read", bus.imem_read, 1'b0);
        step();
        chk1 ("t6_read", bus.imem_read, 1'b1);
        chk16("t6_addr", bus.imem_address, 16'h3000);

        // Reset while parked in SKID.
        for (int i = 0; i < 20 && !bus.if_valid; i++) step();
        bus.stall = 1'b1;
        chk16("t7_word_pc", bus.if_pc, 16'h3000);
        for (int i = 0; i < 20 && bus.imem_read; i++) step();
        chk1("t7_in_skid", bus.imem_read, 1'b0);
        reset_n = 1'b0;
        #1;
        chk1("t7_rst_valid", bus.if_valid, 1'b0);
        chk1("t7_rst_read", bus.imem_read, 1'b0);
        step();
        addr_q.push_back(16'h3000);
        exp_q.push_back('{ir: 16'h1111, pc: 16'h3000});
        reset_n   = 1'b1;
        bus.stall = 1'b0;
        chk1("t7_idle_read", bus.imem_read, 1'b0);
        step();
        chk1 ("t7_read", bus.imem_read, 1'b1);
        chk16("t7_addr", bus.imem_address, 16'h3000);
        for (int i = 0; i < 20 && !bus.if_valid; i++) step();
        mem_en = 1'b0;
        chk16("t7_word_ir", bus.if_ir, 16'h1111);
        step();
        chk1("drain_words", exp_q.size() == 0, 1'b1);
        chk1("drain_addrs", addr_q.size() == 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
